// File: rtl/giraffe_uart_pkg.sv
// Shared constants and state types for the Giraffe host command UART receiver.
package giraffe_uart_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] OPC_NOWA  = 8'h01;
    localparam logic [7:0] OPC_CALIB = 8'h02;
    localparam logic [7:0] OPC_START = 8'h03;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HDR,
        P_OPC,
        P_HI,
        P_LO,
        P_SUM
    } prs_state_t;

    function automatic logic [7:0] frame_sum(input logic [7:0] opc,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        return opc ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1-style UART byte deserialiser: 2-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import giraffe_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 195,
    parameter int UART_NUM_DATA = 8,
    parameter int UART_NUM_STOP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic [1:0]       sync;
    logic             rx_s;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_idx, bit_n;
    logic [7:0]       shreg, sh_n;
    logic             armed, armed_n;
    logic             valid_n, ferr_n;

    assign rx_s      = sync[1];
    assign byte_data = shreg >> (8 - UART_NUM_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            armed      <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rxd};
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            armed      <= armed_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        armed_n = armed;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                // armed only after a high level, so a held-low line never starts a byte
                if (rx_s)       armed_n = 1'b1;
                else if (armed) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, shreg[7:1]};
                    if (bit_idx == 4'(UART_NUM_DATA - 1)) begin
                        bit_n   = '0;
                        state_n = RX_STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        ferr_n  = 1'b1;
                        armed_n = 1'b0;
                        state_n = RX_IDLE;
                    end else if (bit_idx == 4'(UART_NUM_STOP - 1)) begin
                        valid_n = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses 0xA5-framed commands into NOWA / calib / start controls.
// Define UART_CMD_CHECKSUM_EN for the 5-byte frame with XOR checksum; default is 4-byte frames.
module uart_cmd_rx
    import giraffe_uart_pkg::*;
#(
    parameter int BAUDRATE      = 256000,
    parameter int FREQ          = 50_000_000,
    parameter int UART_NUM_DATA = 8,
    parameter int UART_NUM_STOP = 1,
    parameter int TIMEOUT_CYC   = 1_000_000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rxfM,
    output logic [8:0] NOWA_cmd,
    output logic       calib_ena_cmd,
    output logic       start_pulse,
    output logic       cmd_ack,
    output logic       cmd_err,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = FREQ / BAUDRATE;
    localparam int TMO_W        = $clog2(TIMEOUT_CYC + 1);
`ifdef UART_CMD_CHECKSUM_EN
    localparam int HI_W = 8;
`else
    localparam int HI_W = 1;
`endif

    logic [7:0]       byte_data;
    logic             byte_valid, rx_ferr;
    prs_state_t       pstate, pstate_n;
    logic [7:0]       opc_q, opc_n;
    logic [HI_W-1:0]  hi_q, hi_n;
    logic [TMO_W-1:0] tmo, tmo_n;
    logic [8:0]       nowa_n;
    logic             calib_n, start_n, ack_n, err_n;
    logic             do_exec;
    logic [7:0]       ex_lo;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       lo_q, lo_n;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .UART_NUM_DATA(UART_NUM_DATA),
        .UART_NUM_STOP(UART_NUM_STOP)
    ) u_rx (
        .clk       (clk_50M),
        .rst       (rst),
        .rxd       (rxfM),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (rx_ferr)
    );

    assign frame_err = rx_ferr;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            pstate        <= P_HDR;
            opc_q         <= '0;
            hi_q          <= '0;
            tmo           <= '0;
            NOWA_cmd      <= '0;
            calib_ena_cmd <= 1'b0;
            start_pulse   <= 1'b0;
            cmd_ack       <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            pstate        <= pstate_n;
            opc_q         <= opc_n;
            hi_q          <= hi_n;
            tmo           <= tmo_n;
            NOWA_cmd      <= nowa_n;
            calib_ena_cmd <= calib_n;
            start_pulse   <= start_n;
            cmd_ack       <= ack_n;
            cmd_err       <= err_n;
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) lo_q <= '0;
        else     lo_q <= lo_n;
    end
`endif

    always_comb begin
        pstate_n = pstate;
        opc_n    = opc_q;
        hi_n     = hi_q;
        tmo_n    = tmo;
        nowa_n   = NOWA_cmd;
        calib_n  = calib_ena_cmd;
        start_n  = 1'b0;
        ack_n    = 1'b0;
        err_n    = 1'b0;
        do_exec  = 1'b0;
        ex_lo    = byte_data;
`ifdef UART_CMD_CHECKSUM_EN
        lo_n     = lo_q;
`endif
        if (rx_ferr) begin
            pstate_n = P_HDR;
            tmo_n    = '0;
        end else if (byte_valid) begin
            tmo_n = '0;
            case (pstate)
                P_HDR: if (byte_data == HDR_BYTE) pstate_n = P_OPC;
                P_OPC: begin
                    opc_n    = byte_data;
                    pstate_n = P_HI;
                end
                P_HI: begin
                    hi_n     = byte_data[HI_W-1:0];
                    pstate_n = P_LO;
                end
                P_LO: begin
`ifdef UART_CMD_CHECKSUM_EN
                    lo_n     = byte_data;
                    pstate_n = P_SUM;
`else
                    do_exec  = 1'b1;
                    pstate_n = P_HDR;
`endif
                end
`ifdef UART_CMD_CHECKSUM_EN
                P_SUM: begin
                    ex_lo    = lo_q;
                    if (byte_data == frame_sum(opc_q, hi_q, lo_q)) do_exec = 1'b1;
                    else                                           err_n   = 1'b1;
                    pstate_n = P_HDR;
                end
`endif
                default: pstate_n = P_HDR;
            endcase
        end else if (pstate != P_HDR) begin
            // stale partial frame is dropped without any strobe
            if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                pstate_n = P_HDR;
                tmo_n    = '0;
            end else begin
                tmo_n = tmo + 1'b1;
            end
        end

        if (do_exec) begin
            case (opc_q)
                OPC_NOWA: begin
                    nowa_n = {hi_q[0], ex_lo};
                    ack_n  = 1'b1;
                end
                OPC_CALIB: begin
                    calib_n = ex_lo[0];
                    ack_n   = 1'b1;
                end
                OPC_START: begin
                    start_n = 1'b1;
                    ack_n   = 1'b1;
                end
                default: err_n = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised self-checking bench for uart_cmd_rx against a queue-based frame model.
module tb_uart_cmd_rx;

    localparam int FREQ = 2_560_000;
    localparam int BAUD = 256000;
    localparam int CPB  = FREQ / BAUD;
    localparam int TMO  = 3000;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic       rxfM    = 1'b1;
    logic [8:0] NOWA_cmd;
    logic       calib_ena_cmd, start_pulse, cmd_ack, cmd_err, frame_err;

    int n_cmp = 0, n_bad = 0;
    int n_ack = 0, n_err = 0, n_start = 0, n_ferr = 0;
    int e_ack = 0, e_err = 0, e_start = 0, e_ferr = 0;
    logic [8:0] e_nowa  = '0;
    logic       e_calib = 1'b0;
    logic [7:0] mq[$];

    uart_cmd_rx #(
        .BAUDRATE     (BAUD),
        .FREQ         (FREQ),
        .UART_NUM_DATA(8),
        .UART_NUM_STOP(1),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .rxfM         (rxfM),
        .NOWA_cmd     (NOWA_cmd),
        .calib_ena_cmd(calib_ena_cmd),
        .start_pulse  (start_pulse),
        .cmd_ack      (cmd_ack),
        .cmd_err      (cmd_err),
        .frame_err    (frame_err)
    );

    always #5 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        if (!rst) begin
            if (cmd_ack)     n_ack++;
            if (cmd_err)     n_err++;
            if (start_pulse) n_start++;
            if (frame_err)   n_ferr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    // frame semantics from the command rules, applied to whole collected frames
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] opc, hi, lo;
        bit ok;
        if (mq.size() == 0 && b != 8'hA5) return;
        mq.push_back(b);
        if (mq.size() == FLEN) begin
            opc = mq[1]; hi = mq[2]; lo = mq[3];
            ok  = (FLEN == 4) || (mq[FLEN-1] == (opc ^ hi ^ lo));
            if (!ok) e_err++;
            else if (opc == 8'h01) begin e_nowa = {hi[0], lo}; e_ack++; end
            else if (opc == 8'h02) begin e_calib = lo[0]; e_ack++; end
            else if (opc == 8'h03) begin e_start++; e_ack++; end
            else e_err++;
            mq.delete();
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_stop);
        rxfM = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxfM = b[i]; tick(CPB);
        end
        rxfM = ~bad_stop; tick(CPB);
        rxfM = 1'b1; tick(2 * CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0);
        model_byte(b);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_bits(b, 1'b1);
        mq.delete();
        e_ferr++;
    endtask

    task automatic send5(input logic [7:0] a, input logic [7:0] o, input logic [7:0] h,
                         input logic [7:0] l, input logic [7:0] s);
        send_byte(a); send_byte(o); send_byte(h); send_byte(l); send_byte(s);
    endtask

    task automatic check_all(input string tag);
        tick(4);
        chk({tag, "_nowa"},  32'(NOWA_cmd),      32'(e_nowa));
        chk({tag, "_calib"}, 32'(calib_ena_cmd), 32'(e_calib));
        chk({tag, "_ack"},   32'(n_ack),         32'(e_ack));
        chk({tag, "_err"},   32'(n_err),         32'(e_err));
        chk({tag, "_start"}, 32'(n_start),       32'(e_start));
        chk({tag, "_ferr"},  32'(n_ferr),        32'(e_ferr));
    endtask

    initial begin
        logic [7:0] o, h, l, s;
        tick(5);
        chk("rst_nowa",  32'(NOWA_cmd), 32'h0);
        chk("rst_calib", 32'(calib_ena_cmd), 32'h0);
        chk("rst_strb",  32'({start_pulse, cmd_ack, cmd_err, frame_err}), 32'h0);
        rst = 1'b0;
        tick(3 * CPB);

        send5(8'hA5, 8'h01, 8'h01, 8'h2C, 8'h2C); check_all("nowa12c");
        send5(8'hA5, 8'h02, 8'h00, 8'h01, 8'h03); check_all("calib1");
        send5(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03); check_all("start");
        send5(8'hA5, 8'h01, 8'h00, 8'h10, 8'h00); check_all("badsum");
        send5(8'hA5, 8'h01, 8'h01, 8'h55, 8'h55); check_all("after_bad");
        send5(8'hA5, 8'h7E, 8'h00, 8'h00, 8'h7E); check_all("badopc");

        send_byte(8'hA5); send_byte(8'h01); send_bad(8'h00);
        check_all("stopbit");
        send5(8'hA5, 8'h01, 8'h00, 8'h05, 8'h04); check_all("post_ferr");

        // held-low break: one frame_err only, then recover
        rxfM = 1'b0; tick(40 * CPB); rxfM = 1'b1; tick(3 * CPB);
        mq.delete(); e_ferr++;
        check_all("break");

        send_byte(8'hA5); send_byte(8'h01);
        tick(TMO * 6 / 5);
        mq.delete();
        send_byte(8'h00); send_byte(8'h07); send_byte(8'h06);
        check_all("timeout");
        send5(8'hA5, 8'h01, 8'h00, 8'h09, 8'h08); check_all("post_tmo");

        rxfM = 1'b0; tick(3); rxfM = 1'b1; tick(3 * CPB);
        check_all("glitch");

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)));
            case ($urandom_range(0, 4))
                0: o = 8'h01;
                1: o = 8'h02;
                2: o = 8'h03;
                default: o = 8'($urandom_range(0, 255));
            endcase
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            s = o ^ h ^ l;
            if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
            send_byte(8'hA5); send_byte(o); send_byte(h); send_byte(l);
            if (FLEN == 5) send_byte(s);
            check_all("rand");
        end
        tick(TMO + 100);
        mq.delete();

        send5(8'hA5, 8'h01, 8'h01, 8'hF0, 8'hF0);
        send5(8'hA5, 8'h02, 8'h00, 8'h01, 8'h03);
        check_all("pre_rst");
        send_byte(8'hA5); send_byte(8'h01);
        rxfM = 1'b0; tick(3 * CPB);
        rst = 1'b1; tick(3);
        rxfM = 1'b1;
        mq.delete(); e_nowa = '0; e_calib = 1'b0;
        chk("midrst_nowa",  32'(NOWA_cmd), 32'h0);
        chk("midrst_calib", 32'(calib_ena_cmd), 32'h0);
        tick(3); rst = 1'b0; tick(2 * CPB);
        check_all("post_rst_idle");
        send5(8'hA5, 8'h01, 8'h00, 8'h33, 8'h32); check_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
